// File: rtl/mastermind_round_tracker.sv
// Round tracker downstream of the mastermind compare stage: counts rounds, keeps a feedback
// history, detects WIN/LOSE and drives review/display values. Optional: MASTERMIND_BEST_SCORE_EN.
module mastermind_round_tracker #(
  parameter int unsigned MAX_GUESSES = 8,
  parameter int unsigned PEGS        = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       result_valid,
  input  logic [2:0] red_in,
  input  logic [2:0] white_in,
  input  logic       new_game,
  input  logic       review_step,
  output logic [1:0] game_state,
  output logic       guess_lock,
  output logic [3:0] round_count,
  output logic [3:0] disp_round,
  output logic [2:0] disp_red,
  output logic [2:0] disp_white,
  output logic       fb_err,
  output logic [3:0] best_rounds
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FB_W    = 3;
  localparam int unsigned ENTRY_W = 2 * FB_W;
  localparam int unsigned IDX_W   = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_LOSE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     round_q, round_d;
  logic [CNT_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     disp_round_q, disp_round_d;
  logic [FB_W-1:0]      disp_red_q, disp_red_d;
  logic [FB_W-1:0]      disp_white_q, disp_white_d;
  logic                 fb_err_q, fb_err_d;
  logic                 lock_q, lock_d;
  logic [ENTRY_W-1:0]   hist [MAX_GUESSES];
  logic [MAX_GUESSES-1:0] hist_valid;
  logic                 hist_we;
  logic [IDX_W-1:0]     wr_idx;
  logic [CNT_W-1:0]     rev_ptr;
  logic [IDX_W-1:0]     rev_idx;
  logic [ENTRY_W-1:0]   rev_entry;
  logic [CNT_W-1:0]     fb_sum;
  logic                 fb_illegal;
  logic                 enter_win;

  // Feedback legality: sum is computed in 4 bits so 7+7 cannot wrap.
  assign fb_sum     = CNT_W'(red_in) + CNT_W'(white_in);
  assign fb_illegal = (red_in > FB_W'(PEGS)) || (fb_sum > CNT_W'(PEGS));

  // Next review position wraps from the last recorded round back to the first.
  assign rev_ptr   = (ptr_q == round_q - CNT_W'(1)) ? CNT_W'(0) : ptr_q + CNT_W'(1);
  assign rev_idx   = IDX_W'(rev_ptr);
  assign rev_entry = hist_valid[rev_idx] ? hist[rev_idx] : ENTRY_W'(0);
  assign wr_idx    = IDX_W'(round_q);

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    ptr_d        = ptr_q;
    disp_round_d = disp_round_q;
    disp_red_d   = disp_red_q;
    disp_white_d = disp_white_q;
    fb_err_d     = fb_err_q;
    lock_d       = lock_q;
    hist_we      = 1'b0;
    enter_win    = 1'b0;

    if (new_game) begin
      state_d      = ST_PLAY;
      round_d      = '0;
      ptr_d        = '0;
      disp_round_d = '0;
      disp_red_d   = '0;
      disp_white_d = '0;
      fb_err_d     = 1'b0;
      lock_d       = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (result_valid) begin
            hist_we      = 1'b1;
            round_d      = round_q + CNT_W'(1);
            disp_red_d   = red_in;
            disp_white_d = white_in;
            disp_round_d = round_q + CNT_W'(1);
            if (fb_illegal) fb_err_d = 1'b1;
            // Win takes priority over exhausting the budget on the same guess.
            if (!fb_illegal && (red_in == FB_W'(PEGS))) begin
              state_d   = ST_WIN;
              lock_d    = 1'b1;
              ptr_d     = round_q;
              enter_win = 1'b1;
            end else if (round_q + CNT_W'(1) == CNT_W'(MAX_GUESSES)) begin
              state_d = ST_LOSE;
              lock_d  = 1'b1;
              ptr_d   = round_q;
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          if (review_step) begin
            ptr_d        = rev_ptr;
            disp_round_d = rev_ptr + CNT_W'(1);
            disp_red_d   = rev_entry[ENTRY_W-1:FB_W];
            disp_white_d = rev_entry[FB_W-1:0];
          end
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_PLAY;
      round_q      <= '0;
      ptr_q        <= '0;
      disp_round_q <= '0;
      disp_red_q   <= '0;
      disp_white_q <= '0;
      fb_err_q     <= 1'b0;
      lock_q       <= 1'b0;
      hist_valid   <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      ptr_q        <= ptr_d;
      disp_round_q <= disp_round_d;
      disp_red_q   <= disp_red_d;
      disp_white_q <= disp_white_d;
      fb_err_q     <= fb_err_d;
      lock_q       <= lock_d;
      if (hist_we) hist_valid[wr_idx] <= 1'b1;
    end
  end

  // History storage is not reset; the valid bits gate what is ever displayed.
  always_ff @(posedge clk) begin
    if (resetn && hist_we) hist[wr_idx] <= {red_in, white_in};
  end

`ifdef MASTERMIND_BEST_SCORE_EN
  logic [CNT_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (enter_win && ((best_q == CNT_W'(0)) || (round_d < best_q))) best_d = round_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) best_q <= '0;
    else         best_q <= best_d;
  end

  assign best_rounds = best_q;
`else
  logic unused_enter_win;
  assign unused_enter_win = enter_win;
  assign best_rounds      = '0;
`endif

  assign game_state  = 2'(state_q);
  assign guess_lock  = lock_q;
  assign round_count = round_q;
  assign disp_round  = disp_round_q;
  assign disp_red    = disp_red_q;
  assign disp_white  = disp_white_q;
  assign fb_err      = fb_err_q;

endmodule

// File: doc/mastermind_round_tracker.md
Name: mastermind_round_tracker

Overview:
- Sits directly downstream of the mastermind compare/datapath stage.
- Consumes the per-round red/white feedback when the round's compare sequence completes, and counts rounds.
- Detects a win (all pegs red) or a loss (guess budget exhausted), keeps a feedback history, and drives round and feedback values to the HEX decoders.
- Its lock output tells the control FSM to stop accepting guesses once the game is over.

Parameters:
- MAX_GUESSES, 8, guesses allowed per game; legal range 1..15.
- PEGS, 4, code length; a win is red_in == PEGS; legal range 1..7.

Ports:
- clk  input  1  system (slow) clock
- resetn  input  1  reset
- result_valid  input  1  one-cycle pulse: red_in/white_in hold the final feedback of the current round
- red_in  input  3  red peg count for the round
- white_in  input  3  white peg count for the round
- new_game  input  1  one-cycle pulse: start a new game
- review_step  input  1  one-cycle pulse: advance the history review pointer
- game_state  output  2  0=PLAY, 1=WIN, 2=LOSE (3 never driven)
- guess_lock  output  1  high in WIN/LOSE
- round_count  output  4  rounds recorded in the current game
- disp_round  output  4  round number for display
- disp_red  output  3  red count for display
- disp_white  output  3  white count for display
- fb_err  output  1  sticky flag: an illegal feedback was received
- best_rounds  output  4  fewest-round win (see Optional Feature)

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset, state=PLAY and every output = 0, including review pointer, history valid bits and best_rounds.
- All outputs are registered. Effects of an input pulse are visible on the cycle after the sampling edge.
- History: MAX_GUESSES entries of {red[2:0], white[2:0]}, indexed by round (0-based).
- PLAY, result_valid=1:
  - history[round_count] <= {red_in, white_in}; round_count <= round_count+1.
  - disp_red/disp_white <= red_in/white_in; disp_round <= round_count+1.
  - If red_in == PEGS -> WIN.
  - Else if round_count+1 == MAX_GUESSES -> LOSE.
  - Else stay in PLAY.
  - A win on the final allowed guess is a WIN (win is checked first).
- Illegal feedback: red_in > PEGS, or red_in+white_in > PEGS (4-bit sum, no overflow).
  - Sets fb_err, which stays set until new_game or reset.
  - The entry is still recorded and counted.
  - It is never treated as a win, even if red_in == PEGS.
- Entering WIN/LOSE:
  - guess_lock=1 from the next cycle.
  - review pointer <= index of the last recorded round.
  - disp_* show that entry; disp_round = pointer+1.
- WIN/LOSE, review_step=1:
  - pointer <= pointer+1, wrapping from round_count-1 to 0.
  - disp_* <= history[new pointer]; disp_round <= new pointer+1.
- WIN/LOSE, result_valid: ignored, no state or count change.
- PLAY, review_step: ignored.
- new_game, any state:
  - Next state PLAY; round_count, pointer, disp_*, fb_err and guess_lock <= 0.
  - History contents are not cleared; they are overwritten as rounds arrive.
  - best_rounds is untouched.
- Simultaneous events:
  - new_game + result_valid in the same cycle: new_game wins and the result is discarded.
  - new_game + review_step: new_game wins.
- round_count never exceeds MAX_GUESSES.
- result_valid held high for multiple cycles counts once per cycle; the pulse discipline is the upstream stage's responsibility.

Optional Feature:
- Macro: MASTERMIND_BEST_SCORE_EN.
- Defined:
  - On each transition into WIN, if best_rounds == 0 or the winning round_count < best_rounds, then best_rounds <= the winning round_count.
  - Cleared only by resetn; new_game does not clear it.
- Undefined: best_rounds is tied to 0 and no register is built.

Test Plan:
- Reset, then rounds (1,2), (2,1), (4,0) -> round_count=3, game_state=WIN, guess_lock=1, disp_red=4, disp_white=0, disp_round=3.
- MAX_GUESSES=8, eight rounds of (1,1) -> LOSE after the 8th pulse, round_count=8. A 9th result_valid leaves all outputs unchanged.
- In LOSE after 8 rounds, apply review_step ×2 -> disp_round 1 then 2; after 8 more steps disp_round wraps back to 2.
- Feedback (3,2) with PEGS=4 -> fb_err=1, round_count increments, state stays PLAY. new_game clears fb_err to 0.
- new_game and result_valid asserted in the same cycle from WIN -> PLAY, round_count=0, disp_*=0, result not recorded.
- With MASTERMIND_BEST_SCORE_EN: win in 5 rounds, then new_game and a win in 3, then a win in 6 -> best_rounds = 5, 3, 3. Without the macro, best_rounds stays 0.
